// File: rtl/mem_stage.sv
// MIPS MEM pipeline stage: branch resolution, data-memory req/ack access
// with stall and timeout, and the MEM/WB pipeline latch.
//
// Handshake: dmem_req rises on the edge after a load/store is accepted in
// IDLE and stays high, with dmem_we/dmem_addr/dmem_wdata stable, until the
// cycle in which dmem_ack pulses (dmem_rdata valid in that same cycle) or
// the wait counter expires; it drops on the following edge. Upstream holds
// the EX/MEM latch while stall=1 and advances on the edge where stall=0.
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [1:0]  wb_ctl,
    input  logic [2:0]  m_ctl,
    input  logic [31:0] add_result,
    input  logic        zero,
    input  logic [31:0] alu_result,
    input  logic [31:0] rdata2,
    input  logic [4:0]  five_bit_muxout,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [1:0]  wb_ctlout,
    output logic [31:0] read_data,
    output logic [31:0] mem_alu_result,
    output logic [4:0]  write_reg,
    output logic        wb_valid,
    output logic        mem_err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, WR_WAIT = 2'd2} state_t;

    // state is left as a named enum so checkers can bind to it directly
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    cap_wb;
    logic [4:0]    cap_reg;
    logic          mem_op;
    logic          waiting;
    logic          done;
    logic          expire;

    assign mem_op        = in_valid & (m_ctl[1] | m_ctl[0]);
    assign waiting       = (state != IDLE);
    assign done          = waiting & dmem_ack;
    // an ack in the final wait cycle takes priority over the timeout
    assign expire        = waiting & ~dmem_ack & (cnt == LAST_CNT);
    assign pc_src        = in_valid & m_ctl[2] & zero & (state == IDLE);
    assign branch_target = add_result;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state and stall decode
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    stall     = 1'b1;
                    state_nxt = m_ctl[1] ? RD_WAIT : WR_WAIT;
                end
            end
            RD_WAIT, WR_WAIT: begin
                stall = ~dmem_ack & ~expire;
                if (done | expire) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // memory interface, captured fields, wait counter, error flag and MEM/WB latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            cap_wb         <= '0;
            cap_reg        <= '0;
            cnt            <= '0;
            mem_err        <= 1'b0;
            wb_ctlout      <= '0;
            read_data      <= '0;
            mem_alu_result <= '0;
            write_reg      <= '0;
            wb_valid       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= ~m_ctl[1];
                        dmem_addr  <= alu_result;
                        dmem_wdata <= rdata2;
                        cap_wb     <= wb_ctl;
                        cap_reg    <= five_bit_muxout;
                        cnt        <= '0;
                        wb_valid   <= 1'b0;
                        wb_ctlout  <= '0;
                    end else if (in_valid) begin
                        wb_ctlout      <= wb_ctl;
                        mem_alu_result <= alu_result;
                        write_reg      <= five_bit_muxout;
                        read_data      <= '0;
                        wb_valid       <= 1'b1;
                    end else begin
                        wb_valid  <= 1'b0;
                        wb_ctlout <= '0;
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (done) begin
                        dmem_req       <= 1'b0;
                        wb_ctlout      <= cap_wb;
                        mem_alu_result <= dmem_addr;
                        write_reg      <= cap_reg;
                        read_data      <= (state == RD_WAIT) ? dmem_rdata : '0;
                        wb_valid       <= 1'b1;
                    end else if (expire) begin
                        dmem_req  <= 1'b0;
                        mem_err   <= 1'b1;
                        wb_valid  <= 1'b0;
                        wb_ctlout <= '0;
                    end else begin
                        cnt       <= cnt + CW'(1);
                        wb_valid  <= 1'b0;
                        wb_ctlout <= '0;
                    end
                end
                default: begin
                    dmem_req  <= 1'b0;
                    wb_valid  <= 1'b0;
                    wb_ctlout <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed steps followed by a randomized mix of ALU,
// branch, load, store and bubble cycles, checked against a transaction-level
// model of the MEM/WB latch and error flag.
module tb_mem_stage;
    localparam int TO = 4;
    localparam int W  = 72;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  wb_ctl;
    logic [2:0]  m_ctl;
    logic [31:0] add_result;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] rdata2;
    logic [4:0]  five_bit_muxout;
    logic        stall;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic [1:0]  wb_ctlout;
    logic [31:0] read_data;
    logic [31:0] mem_alu_result;
    logic [4:0]  write_reg;
    logic        wb_valid;
    logic        mem_err;

    int checks   = 0;
    int failures = 0;

    // model: expected MEM/WB contents and error flag
    logic [W-1:0] exp_q[$];
    logic [1:0]   cur_wb;
    logic [31:0]  cur_rd;
    logic [31:0]  cur_alu;
    logic [4:0]   cur_reg;
    logic         cur_v;
    logic         exp_err;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .wb_ctl(wb_ctl),
        .m_ctl(m_ctl), .add_result(add_result), .zero(zero),
        .alu_result(alu_result), .rdata2(rdata2), .five_bit_muxout(five_bit_muxout),
        .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_ctlout(wb_ctlout), .read_data(read_data), .mem_alu_result(mem_alu_result),
        .write_reg(write_reg), .wb_valid(wb_valid), .mem_err(mem_err)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp();
        exp_q.push_back({cur_wb, cur_rd, cur_alu, cur_reg, cur_v});
    endtask

    // scoreboard: compare MEM/WB against the oldest expected record
    task automatic check_wb(input string tag);
        logic [W-1:0] e;
        checks++;
        assert (exp_q.size() > 0) else begin
            failures++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_wb_valid"}, {31'd0, wb_valid}, {31'd0, e[0]});
            check({tag, "_wb_ctlout"}, {30'd0, wb_ctlout}, {30'd0, e[71:70]});
            check({tag, "_write_reg"}, {27'd0, write_reg}, {27'd0, e[5:1]});
            check({tag, "_alu_result"}, mem_alu_result, e[37:6]);
            check({tag, "_read_data"}, read_data, e[69:38]);
        end
    endtask

    // driver: ALU or branch instruction (m_ctl[1:0]=00)
    task automatic do_alu(input logic [2:0] m, input logic [1:0] wb, input logic [31:0] alu,
                          input logic [4:0] wr, input logic z, input logic [31:0] tgt);
        in_valid = 1'b1; m_ctl = m; wb_ctl = wb; alu_result = alu;
        five_bit_muxout = wr; zero = z; add_result = tgt; rdata2 = $urandom; dmem_ack = 1'b0;
        @(negedge clk);
        check("alu_stall", {31'd0, stall}, 32'd0);
        check("alu_pc_src", {31'd0, pc_src}, {31'd0, m[2] & z});
        check("alu_branch_target", branch_target, tgt);
        step();
        in_valid = 1'b0;
        cur_wb = wb; cur_rd = 32'd0; cur_alu = alu; cur_reg = wr; cur_v = 1'b1;
        push_exp();
        check_wb("alu");
        check("alu_req", {31'd0, dmem_req}, 32'd0);
    endtask

    // driver: bubble cycle, optionally with a stray ack that must be ignored
    task automatic do_bubble(input logic ack);
        in_valid = 1'b0; m_ctl = 3'($urandom); zero = $urandom; dmem_ack = ack;
        @(negedge clk);
        check("bub_stall", {31'd0, stall}, 32'd0);
        check("bub_pc_src", {31'd0, pc_src}, 32'd0);
        step();
        dmem_ack = 1'b0;
        cur_v = 1'b0; cur_wb = 2'b00;
        push_exp();
        check_wb("bub");
        check("bub_req", {31'd0, dmem_req}, 32'd0);
    endtask

    // driver: load/store; ack arrives in wait cycle 'delay' (0-based), none if delay >= TO
    task automatic do_mem(input logic [1:0] m, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic [1:0] wb, input logic [4:0] wr,
                          input int delay);
        logic is_rd;
        logic last;
        int   k;
        is_rd = m[1];
        in_valid = 1'b1; m_ctl = {1'b0, m}; alu_result = addr; rdata2 = wdata;
        wb_ctl = wb; five_bit_muxout = wr; zero = $urandom; add_result = $urandom; dmem_ack = 1'b0;
        @(negedge clk);
        check("mem_idle_stall", {31'd0, stall}, 32'd1);
        check("mem_idle_pc_src", {31'd0, pc_src}, 32'd0);
        step();
        k = 0;
        last = 1'b0;
        while (!last) begin
            dmem_ack   = (k == delay);
            dmem_rdata = (k == delay) ? rdata : $urandom;
            last       = (k == delay) || (k == TO - 1);
            @(negedge clk);
            check("mem_req", {31'd0, dmem_req}, 32'd1);
            check("mem_we", {31'd0, dmem_we}, {31'd0, ~is_rd});
            check("mem_addr", dmem_addr, addr);
            if (!is_rd) check("mem_wdata", dmem_wdata, wdata);
            check("mem_wait_stall", {31'd0, stall}, {31'd0, ~last});
            check("mem_wait_valid", {31'd0, wb_valid}, 32'd0);
            check("mem_wait_pc_src", {31'd0, pc_src}, 32'd0);
            step();
            dmem_ack = 1'b0;
            k++;
        end
        in_valid = 1'b0;
        if (delay < TO) begin
            cur_wb = wb; cur_rd = is_rd ? rdata : 32'd0; cur_alu = addr; cur_reg = wr; cur_v = 1'b1;
        end else begin
            exp_err = 1'b1;
            cur_wb = 2'b00; cur_v = 1'b0;
        end
        push_exp();
        check_wb("mem");
        check("mem_done_req", {31'd0, dmem_req}, 32'd0);
        check("mem_err", {31'd0, mem_err}, {31'd0, exp_err});
    endtask

    // stimulus
    initial begin
        rst_n = 1'b0; in_valid = 1'b0; wb_ctl = 2'b00; m_ctl = 3'b000; add_result = 32'd0;
        zero = 1'b0; alu_result = 32'd0; rdata2 = 32'd0; five_bit_muxout = 5'd0;
        dmem_rdata = 32'd0; dmem_ack = 1'b0;
        cur_wb = 2'b00; cur_rd = 32'd0; cur_alu = 32'd0; cur_reg = 5'd0; cur_v = 1'b0;
        exp_err = 1'b0;

        repeat (2) step();
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_we", {31'd0, dmem_we}, 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_err", {31'd0, mem_err}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        push_exp();
        check_wb("rst");
        rst_n = 1'b1;
        step();

        do_alu(3'b000, 2'b10, 32'h0000_0010, 5'd5, 1'b0, 32'd0);
        do_mem(2'b10, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 2'b11, 5'd7, 2);
        do_mem(2'b01, 32'h0000_0200, 32'h0000_1234, 32'h0, 2'b00, 5'd0, 0);
        do_mem(2'b11, 32'h0000_0300, 32'h5555_AAAA, 32'hCAFE_F00D, 2'b11, 5'd9, TO - 1);
        do_mem(2'b10, 32'h0000_0400, 32'h0, 32'h1111_2222, 2'b11, 5'd3, 99);
        do_alu(3'b000, 2'b10, 32'h0000_0044, 5'd12, 1'b1, 32'd0);
        do_alu(3'b100, 2'b00, 32'h0000_0000, 5'd0, 1'b1, 32'h0000_0040);
        do_alu(3'b100, 2'b00, 32'h0000_0000, 5'd0, 1'b0, 32'h0000_0040);
        do_bubble(1'b1);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0: do_alu(3'b000, 2'($urandom), $urandom, 5'($urandom), 1'($urandom), $urandom);
                1: do_alu(3'b100, 2'b00, $urandom, 5'($urandom), 1'($urandom), $urandom);
                2: do_mem({1'b1, 1'($urandom)}, $urandom, $urandom, $urandom, 2'($urandom),
                          5'($urandom), $urandom_range(0, 5));
                3: do_mem(2'b01, $urandom, $urandom, $urandom, 2'($urandom),
                          5'($urandom), $urandom_range(0, 5));
                default: do_bubble(1'($urandom));
            endcase
        end

        // asynchronous reset in the middle of a load wait
        if (!exp_err) do_mem(2'b10, 32'h0000_0500, 32'h0, 32'h0, 2'b11, 5'd1, 99);
        in_valid = 1'b1; m_ctl = 3'b010; alu_result = 32'h0000_0600; wb_ctl = 2'b11;
        five_bit_muxout = 5'd2; dmem_ack = 1'b0;
        step();
        @(negedge clk);
        check("rstmid_pre_req", {31'd0, dmem_req}, 32'd1);
        check("rstmid_pre_err", {31'd0, mem_err}, 32'd1);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rstmid_req", {31'd0, dmem_req}, 32'd0);
        check("rstmid_stall", {31'd0, stall}, 32'd0);
        check("rstmid_valid", {31'd0, wb_valid}, 32'd0);
        check("rstmid_err", {31'd0, mem_err}, 32'd0);
        step();
        rst_n = 1'b1;
        cur_wb = 2'b00; cur_rd = 32'd0; cur_alu = 32'd0; cur_reg = 5'd0; cur_v = 1'b0;
        exp_err = 1'b0;
        step();
        do_alu(3'b000, 2'b10, 32'h0000_0077, 5'd31, 1'b0, 32'd0);
        do_mem(2'b10, 32'h0000_0700, 32'h0, 32'h7777_0000, 2'b11, 5'd4, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
